xif_mac_coproc: RTL

//  Coprocessor on the CV-X-IF eXtension port of cv32e40x_top: consumes the issue/commit stream, executes custom-0

---
 rtl/xif_mac_coproc_if.sv | 66 ++++++
 rtl/xif_mac_coproc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/xif_mac_coproc_if.sv
// CV-X-IF signal bundle between the core (master) and the MAC coprocessor (slave).
interface xif_mac_coproc_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 2,
  parameter int XLEN       = 32
);
  logic                       compressed_valid;
  logic                       compressed_ready;
  logic                       compressed_resp_accept;
  logic [31:0]                compressed_resp_instr;

  logic                       issue_valid;
  logic                       issue_ready;
  logic [31:0]                issue_req_instr;
  logic [X_ID_WIDTH-1:0]      issue_req_id;
  logic [X_NUM_RS*XLEN-1:0]   issue_req_rs;
  logic [X_NUM_RS-1:0]        issue_req_rs_valid;
  logic                       issue_resp_accept;
  logic                       issue_resp_writeback;
  logic                       issue_resp_dualwrite;
  logic [2:0]                 issue_resp_dualread;
  logic                       issue_resp_loadstore;
  logic                       issue_resp_ecswrite;
  logic                       issue_resp_exc;

  logic                       commit_valid;
  logic [X_ID_WIDTH-1:0]      commit_id;
  logic                       commit_kill;

  logic                       result_valid;
  logic                       result_ready;
  logic [X_ID_WIDTH-1:0]      result_id;
  logic [XLEN-1:0]            result_data;
  logic [4:0]                 result_rd;
  logic                       result_we;
  logic [5:0]                 result_ecsdata;
  logic [2:0]                 result_ecswe;
  logic                       result_exc;
  logic [5:0]                 result_exccode;
  logic                       result_err;
  logic                       result_dbg;

  modport slave (
    input  compressed_valid,
    output compressed_ready, compressed_resp_accept, compressed_resp_instr,
    input  issue_valid, issue_req_instr, issue_req_id, issue_req_rs, issue_req_rs_valid,
    output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_dualwrite,
           issue_resp_dualread, issue_resp_loadstore, issue_resp_ecswrite, issue_resp_exc,
    input  commit_valid, commit_id, commit_kill,
    output result_valid, result_id, result_data, result_rd, result_we, result_ecsdata,
           result_ecswe, result_exc, result_exccode, result_err, result_dbg,
    input  result_ready
  );

  modport master (
    output compressed_valid,
    input  compressed_ready, compressed_resp_accept, compressed_resp_instr,
    output issue_valid, issue_req_instr, issue_req_id, issue_req_rs, issue_req_rs_valid,
    input  issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_dualwrite,
           issue_resp_dualread, issue_resp_loadstore, issue_resp_ecswrite, issue_resp_exc,
    output commit_valid, commit_id, commit_kill,
    input  result_valid, result_id, result_data, result_rd, result_we, result_ecsdata,
           result_ecswe, result_exc, result_exccode, result_err, result_dbg,
    output result_ready
  );
endinterface

// File: rtl/xif_mac_coproc.sv
// Custom-0 multiply/accumulate coprocessor on the CV-X-IF port.
// Accepted instructions wait in an in-order queue until the core commits or kills them;
// the head entry is then executed and its rd value returned on the result interface.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for the queue head to be committed or killed
// S_EXEC   | multiplier latency down-counter running for MUL/MAC
// S_RESULT | result registered and presented until the core accepts it
module xif_mac_coproc #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_NUM_RS    = 2,
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2,
  parameter int MUL_LATENCY = 3
) (
  input logic             clk_i,
  input logic             rst_ni,
  xif_mac_coproc_if.slave xif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  localparam logic [1:0] OP_MAC    = 2'b00;
  localparam logic [1:0] OP_MUL    = 2'b01;
  localparam logic [1:0] OP_CLRACC = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESULT} state_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic [1:0]            op;
    logic [XLEN-1:0]       rs1;
    logic [XLEN-1:0]       rs2;
  } entry_t;

  entry_t                r_q [DEPTH];
  logic [DEPTH-1:0]      r_vld, r_cmt, r_kill;
  logic [PW-1:0]         r_head, r_tail;
  logic [NW-1:0]         r_count;
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [XLEN-1:0]       r_acc;
  logic [XLEN-1:0]       r_res_data;
  logic [X_ID_WIDTH-1:0] r_res_id;
  logic [4:0]            r_res_rd;
  logic [1:0]            r_res_op;

  logic                  w_match, w_full, w_enq, w_pop, w_cnt_load, w_res_load, w_res_hs;
  logic                  w_cmt_new;
  entry_t                w_new, w_head;
  logic [XLEN-1:0]       w_prod, w_res_data;
  logic                  w_unused;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Tie-offs for features this coprocessor does not implement.
  assign xif.compressed_ready       = 1'b1;
  assign xif.compressed_resp_accept = 1'b0;
  assign xif.compressed_resp_instr  = '0;
  assign xif.issue_resp_dualwrite   = 1'b0;
  assign xif.issue_resp_dualread    = '0;
  assign xif.issue_resp_loadstore   = 1'b0;
  assign xif.issue_resp_ecswrite    = 1'b0;
  assign xif.issue_resp_exc         = 1'b0;
  assign xif.result_ecsdata         = '0;
  assign xif.result_ecswe           = '0;
  assign xif.result_exc             = 1'b0;
  assign xif.result_exccode         = '0;
  assign xif.result_err             = 1'b0;
  assign xif.result_dbg             = 1'b0;

  assign w_unused = ^{xif.compressed_valid, xif.issue_req_instr[24:15],
                      xif.issue_req_rs, xif.issue_req_rs_valid};

  // custom-0 opcode, funct7 zero, funct3 0..3 (bit 14 clear)
  assign w_match = (xif.issue_req_instr[6:0] == 7'b0001011) &&
                   (xif.issue_req_instr[31:25] == 7'd0) && !xif.issue_req_instr[14];
  assign w_full  = (r_count == NW'(DEPTH));

  assign xif.issue_ready          = w_match ? (!w_full && (xif.issue_req_rs_valid[1:0] == 2'b11)) : 1'b1;
  assign xif.issue_resp_accept    = w_match;
  assign xif.issue_resp_writeback = w_match;

  assign w_enq     = xif.issue_valid && xif.issue_ready && w_match;
  assign w_cmt_new = xif.commit_valid && (xif.commit_id == xif.issue_req_id);

  assign w_new.id  = xif.issue_req_id;
  assign w_new.rd  = xif.issue_req_instr[11:7];
  assign w_new.op  = xif.issue_req_instr[13:12];
  assign w_new.rs1 = xif.issue_req_rs[XLEN-1:0];
  assign w_new.rs2 = xif.issue_req_rs[2*XLEN-1:XLEN];

  assign w_head = r_q[r_head];
  assign w_prod = w_head.rs1 * w_head.rs2;

  // Payload storage; contents are only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_q[r_tail] <= w_new;
  end

  // Queue pointers, occupancy and per-entry commit/kill flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      r_cmt   <= '0;
      r_kill  <= '0;
    end else begin
      if (w_enq) r_tail <= f_inc(r_tail);
      if (w_pop) r_head <= f_inc(r_head);
      if (w_enq && !w_pop)      r_count <= r_count + NW'(1);
      else if (!w_enq && w_pop) r_count <= r_count - NW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pop && (PW'(i) == r_head)) begin
          r_vld[i]  <= 1'b0;
          r_cmt[i]  <= 1'b0;
          r_kill[i] <= 1'b0;
        end else if (w_enq && (PW'(i) == r_tail)) begin
          r_vld[i]  <= 1'b1;
          r_cmt[i]  <= w_cmt_new && !xif.commit_kill;
          r_kill[i] <= w_cmt_new && xif.commit_kill;
        end else if (r_vld[i] && xif.commit_valid && (xif.commit_id == r_q[i].id)) begin
          if (xif.commit_kill) r_kill[i] <= 1'b1;
          else                 r_cmt[i]  <= 1'b1;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_cnt_load  = 1'b0;
    w_res_load  = 1'b0;
    w_res_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_vld[r_head]) begin
          if (r_kill[r_head]) begin
            w_pop = 1'b1;
          end else if (r_cmt[r_head]) begin
            if (!w_head.op[1]) begin
              w_state_nxt = S_EXEC;
              w_cnt_load  = 1'b1;
            end else begin
              w_state_nxt = S_RESULT;
              w_res_load  = 1'b1;
            end
          end
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESULT;
          w_res_load  = 1'b1;
        end
      end
      S_RESULT: begin
        if (xif.result_ready) begin
          w_pop       = 1'b1;
          w_res_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplier latency down-counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                               r_cnt <= '0;
    else if (w_cnt_load)                       r_cnt <= CW'(MUL_LATENCY - 1);
    else if (r_state == S_EXEC && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
  end

  // rd value for the head instruction; MAC reports the post-accumulate value.
  always_comb begin
    w_res_data = r_acc;
    case (w_head.op)
      OP_MAC:  w_res_data = r_acc + w_prod;
      OP_MUL:  w_res_data = w_prod;
      default: w_res_data = r_acc;
    endcase
  end

  // Result registers, held stable while the core back-pressures.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_data <= '0;
      r_res_id   <= '0;
      r_res_rd   <= '0;
      r_res_op   <= '0;
    end else if (w_res_load) begin
      r_res_data <= w_res_data;
      r_res_id   <= w_head.id;
      r_res_rd   <= w_head.rd;
      r_res_op   <= w_head.op;
    end
  end

  // Accumulator changes only when the result is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else if (w_res_hs) begin
      if (r_res_op == OP_MAC)         r_acc <= r_res_data;
      else if (r_res_op == OP_CLRACC) r_acc <= '0;
    end
  end

  assign xif.result_valid = (r_state == S_RESULT);
  assign xif.result_we    = (r_state == S_RESULT);
  assign xif.result_data  = r_res_data;
  assign xif.result_id    = r_res_id;
  assign xif.result_rd    = r_res_rd;

endmodule
